// File: rtl/gbuf_out_drain.sv
// rtl/gbuf_out_drain.sv - host-side drain of the output global buffer
// Walks GBUFF_OUT row-major and streams lane-masked result words over valid/ready.
module gbuf_out_drain #(
  parameter int WORD_W   = 128,
  parameter int ELEM_W   = 32,
  parameter int IDX_W    = 16,
  parameter int BASE_IDX = 0,
  parameter int RD_LAT   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [3:0]               m,
  input  logic [3:0]               n,
  output logic [IDX_W-1:0]         index_out,
  output logic                     rd_en,
  input  logic [WORD_W-1:0]        data_out_o,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W-1:0]        out_data,
  output logic [WORD_W/ELEM_W-1:0] out_keep,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);
  localparam int LANES = WORD_W / ELEM_W;
  localparam int CNT_W = 8;

  // The issue/return pipeline below is built for a single-cycle buffer read.
  if (RD_LAT != 1) begin : g_rd_lat_unsupported
  end

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, FIN} state_t;

  function automatic logic [LANES-1:0] keep_for(input logic [3:0] col,
                                                input logic [3:0] wpr,
                                                input logic [3:0] n_val);
    logic [LANES-1:0] k;
    int rem;
    k = '1;
    if (col == wpr - 4'd1) begin
      rem = int'(n_val) - int'(col) * LANES;
      for (int i = 0; i < LANES; i++) begin
        if (i >= rem) k[i] = 1'b0;
      end
    end
    return k;
  endfunction

  function automatic logic [WORD_W-1:0] mask_lanes(input logic [WORD_W-1:0] d,
                                                   input logic [LANES-1:0] k);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      if (k[i]) r[i*ELEM_W +: ELEM_W] = d[i*ELEM_W +: ELEM_W];
    end
    return r;
  endfunction

  state_t           state;
  logic [3:0]       n_q;
  logic [3:0]       wpr_q;
  logic [CNT_W-1:0] total_q;
  logic [CNT_W-1:0] issue_cnt;
  logic [3:0]       col;
  logic [LANES-1:0] tag_keep;
  logic             tag_last;

  logic             rd_v;
  logic [LANES-1:0] bus_keep;
  logic             bus_last;
  logic [WORD_W-1:0] bus_word;

  logic [WORD_W-1:0] mem_data [2];
  logic [LANES-1:0]  mem_keep [2];
  logic              mem_last [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [1:0]        count_next;

  logic [3:0]       wpr_in;
  logic [CNT_W-1:0] total_in;
  logic             head_stored;
  logic             pop;
  logic             bypass;
  logic             store;
  logic             credit_ok;

  assign wpr_in   = 4'((int'(n) + LANES - 1) / LANES);
  assign total_in = CNT_W'(m) * CNT_W'(wpr_in);
  assign bus_word = mask_lanes(data_out_o, bus_keep);

  // An empty FIFO presents the returning word directly, which keeps the
  // issue-to-credit loop at two cycles so two entries sustain full rate.
  assign head_stored = (count != 2'd0);
  assign out_valid   = head_stored || rd_v;
  assign pop         = out_valid && out_ready;
  assign bypass      = !head_stored && rd_v && out_ready;
  assign store       = rd_v && !bypass;
  assign count_next  = count + {1'b0, store} - {1'b0, pop && head_stored};
  assign credit_ok   = ({1'b0, count_next} + {2'b0, rd_en}) < 3'd2;

  assign out_data = head_stored ? mem_data[rd_ptr] : (rd_v ? bus_word : '0);
  assign out_keep = head_stored ? mem_keep[rd_ptr] : (rd_v ? bus_keep : '0);
  assign out_last = head_stored ? mem_last[rd_ptr] : (rd_v && bus_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      index_out <= '0;
      n_q       <= '0;
      wpr_q     <= '0;
      total_q   <= '0;
      issue_cnt <= '0;
      col       <= '0;
      tag_keep  <= '0;
      tag_last  <= 1'b0;
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n_q     <= n;
            wpr_q   <= wpr_in;
            total_q <= total_in;
            busy    <= 1'b1;
            if (total_in == '0) begin
              state <= FIN;
            end else begin
              rd_en     <= 1'b1;
              index_out <= IDX_W'(BASE_IDX);
              issue_cnt <= CNT_W'(1);
              col       <= (wpr_in == 4'd1) ? 4'd0 : 4'd1;
              tag_keep  <= keep_for(4'd0, wpr_in, n);
              tag_last  <= (total_in == CNT_W'(1));
              state     <= (total_in == CNT_W'(1)) ? FLUSH : DRAIN;
            end
          end
        end
        DRAIN: begin
          if (issue_cnt < total_q && credit_ok) begin
            rd_en     <= 1'b1;
            index_out <= IDX_W'(BASE_IDX) + IDX_W'(issue_cnt);
            issue_cnt <= issue_cnt + CNT_W'(1);
            col       <= (col == wpr_q - 4'd1) ? 4'd0 : col + 4'd1;
            tag_keep  <= keep_for(col, wpr_q, n_q);
            tag_last  <= (issue_cnt == total_q - CNT_W'(1));
            if (issue_cnt + CNT_W'(1) == total_q) state <= FLUSH;
          end
        end
        FLUSH: begin
          // Finishes on the edge that accepts the final word.
          if (!rd_en && count_next == 2'd0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v     <= 1'b0;
      bus_keep <= '0;
      bus_last <= 1'b0;
      count    <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      rd_v     <= rd_en;
      bus_keep <= tag_keep;
      bus_last <= tag_last;
      if (store) begin
        mem_data[wr_ptr] <= bus_word;
        mem_keep[wr_ptr] <= bus_keep;
        mem_last[wr_ptr] <= bus_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop && head_stored) rd_ptr <= ~rd_ptr;
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_gbuf_out_drain.sv
// tb/tb_gbuf_out_drain.sv - directed self-checking bench for gbuf_out_drain
module tb_gbuf_out_drain;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   m;
  logic [3:0]   n;
  logic [15:0]  index_out;
  logic         rd_en;
  logic [127:0] data_out_o;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   out_keep;
  logic         out_last;
  logic         busy;
  logic         done;

  gbuf_out_drain dut (
    .clk(clk), .rst(rst), .start(start), .m(m), .n(n),
    .index_out(index_out), .rd_en(rd_en), .data_out_o(data_out_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [127:0] bufm [0:63];
  always @(posedge clk) data_out_o <= bufm[index_out[5:0]];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int           cyc = 0;
  logic [15:0]  rd_idx_q [$];
  int           rd_cyc_q [$];
  logic [127:0] acc_data_q [$];
  logic [3:0]   acc_keep_q [$];
  logic         acc_last_q [$];
  int           acc_cyc_q [$];
  int           done_cyc_q [$];
  int           start_cyc_q [$];
  int           first_valid;
  int           busy_n;
  int           stab_err;
  int           max_out;
  bit           stall_q;
  logic [127:0] hold_data;
  logic [3:0]   hold_keep;
  logic         hold_last;
  logic [3:0]   exp_keep [0:63];

  task automatic clear_mon();
    rd_idx_q.delete(); rd_cyc_q.delete();
    acc_data_q.delete(); acc_keep_q.delete(); acc_last_q.delete(); acc_cyc_q.delete();
    done_cyc_q.delete(); start_cyc_q.delete();
    first_valid = -1; busy_n = 0; stab_err = 0; max_out = 0; stall_q = 0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (start) start_cyc_q.push_back(cyc);
    if (busy) busy_n++;
    if (done) done_cyc_q.push_back(cyc);
    if (rd_en) begin
      rd_idx_q.push_back(index_out);
      rd_cyc_q.push_back(cyc);
    end
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (rd_idx_q.size() - acc_data_q.size() > max_out) max_out = rd_idx_q.size() - acc_data_q.size();
    if (stall_q && (!out_valid || out_data !== hold_data || out_keep !== hold_keep || out_last !== hold_last))
      stab_err++;
    stall_q   = out_valid && !out_ready;
    hold_data = out_data;
    hold_keep = out_keep;
    hold_last = out_last;
    if (out_valid && out_ready) begin
      acc_data_q.push_back(out_data);
      acc_keep_q.push_back(out_keep);
      acc_last_q.push_back(out_last);
      acc_cyc_q.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lane_val(input int seed, input int w, input int l);
    if (seed == 0) return 32'(w);
    return {8'(seed), 8'(w), 8'(l), 8'h5A};
  endfunction

  function automatic logic [127:0] exp_word(input int seed, input int w, input logic [3:0] k);
    logic [127:0] r;
    r = '0;
    for (int l = 0; l < 4; l++) if (k[l]) r[l*32 +: 32] = lane_val(seed, w, l);
    return r;
  endfunction

  task automatic fill(input int seed);
    for (int w = 0; w < 64; w++)
      for (int l = 0; l < 4; l++) bufm[w][l*32 +: 32] = lane_val(seed, w, l);
  endtask

  task automatic do_start(input logic [3:0] mm, input logic [3:0] nn);
    m = mm; n = nn; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run(input string tag, input int budget, input bit toggle);
    int k;
    k = 0;
    while (done_cyc_q.size() == 0 && k < budget) begin
      if (toggle) out_ready = (k % 3 == 0);
      tick();
      k++;
    end
    check_eq({tag, "_done_seen"}, 128'(done_cyc_q.size() != 0), 128'(1));
    out_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic check_run(input string tag, input int seed, input int nw);
    check_eq({tag, "_nrd"}, 128'(rd_idx_q.size()), 128'(nw));
    check_eq({tag, "_nacc"}, 128'(acc_data_q.size()), 128'(nw));
    check_eq({tag, "_ndone"}, 128'(done_cyc_q.size()), 128'(1));
    for (int w = 0; w < nw; w++) begin
      if (w < rd_idx_q.size())
        check_eq($sformatf("%s_idx%0d", tag, w), 128'(rd_idx_q[w]), 128'(w));
      if (w < acc_data_q.size()) begin
        check_eq($sformatf("%s_data%0d", tag, w), acc_data_q[w], exp_word(seed, w, exp_keep[w]));
        check_eq($sformatf("%s_keep%0d", tag, w), 128'(acc_keep_q[w]), 128'(exp_keep[w]));
        check_eq($sformatf("%s_last%0d", tag, w), 128'(acc_last_q[w]), 128'(w == nw - 1));
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_valid"}, 128'(out_valid), 128'(0));
    check_eq({tag, "_rd_en"}, 128'(rd_en), 128'(0));
    check_eq({tag, "_busy"}, 128'(busy), 128'(0));
    check_eq({tag, "_done"}, 128'(done), 128'(0));
    check_eq({tag, "_data"}, out_data, 128'(0));
    check_eq({tag, "_keep"}, 128'(out_keep), 128'(0));
    check_eq({tag, "_last"}, 128'(out_last), 128'(0));
    check_eq({tag, "_index"}, 128'(index_out), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; m = '0; n = '0; out_ready = 1'b1;
    fill(1);
    repeat (2) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Test 1: m=2, n=8 -> 4 full words back-to-back
    clear_mon();
    for (int w = 0; w < 4; w++) exp_keep[w] = 4'hF;
    do_start(4'd2, 4'd8);
    run("t1", 100, 1'b0);
    check_run("t1", 1, 4);
    if (rd_cyc_q.size() == 4 && acc_cyc_q.size() == 4 && done_cyc_q.size() >= 1 && start_cyc_q.size() >= 1) begin
      check_eq("t1_rd_lat", 128'(rd_cyc_q[0] - start_cyc_q[0]), 128'(1));
      check_eq("t1_rd_b2b", 128'(rd_cyc_q[3] - rd_cyc_q[0]), 128'(3));
      check_eq("t1_valid_lat", 128'(first_valid - start_cyc_q[0]), 128'(2));
      check_eq("t1_acc_b2b", 128'(acc_cyc_q[3] - acc_cyc_q[0]), 128'(3));
      check_eq("t1_done_after_last", 128'(done_cyc_q[0] - acc_cyc_q[3]), 128'(1));
    end else begin
      check_eq("t1_timing_samples", 128'(acc_cyc_q.size()), 128'(4));
    end

    // Test 2: m=3, n=5 -> alternating full and single-lane words
    clear_mon();
    fill(0);
    for (int w = 0; w < 6; w++) exp_keep[w] = (w % 2 == 1) ? 4'b0001 : 4'hF;
    do_start(4'd3, 4'd5);
    run("t2", 100, 1'b0);
    check_run("t2", 0, 6);

    // Test 3: m=4, n=4 with out_ready pattern 1,0,0
    clear_mon();
    fill(2);
    for (int w = 0; w < 4; w++) exp_keep[w] = 4'hF;
    do_start(4'd4, 4'd4);
    run("t3", 200, 1'b1);
    check_run("t3", 2, 4);
    check_eq("t3_stable", 128'(stab_err), 128'(0));
    check_eq("t3_outstanding_le2", 128'(max_out <= 2), 128'(1));

    // Test 4: empty geometries
    for (int t = 0; t < 2; t++) begin
      clear_mon();
      if (t == 0) do_start(4'd0, 4'd7);
      else do_start(4'd5, 4'd0);
      run($sformatf("t4_%0d", t), 20, 1'b0);
      check_eq($sformatf("t4_%0d_nrd", t), 128'(rd_idx_q.size()), 128'(0));
      check_eq($sformatf("t4_%0d_valid", t), 128'(first_valid), 128'(-1));
      check_eq($sformatf("t4_%0d_busy_cycles", t), 128'(busy_n), 128'(1));
      check_eq($sformatf("t4_%0d_ndone", t), 128'(done_cyc_q.size()), 128'(1));
      if (done_cyc_q.size() > 0 && start_cyc_q.size() > 0)
        check_eq($sformatf("t4_%0d_done_lat", t), 128'(done_cyc_q[0] - start_cyc_q[0]), 128'(2));
    end

    // Test 5: reset during a 15x15 drain, then a 1x3 run
    clear_mon();
    fill(4);
    do_start(4'd15, 4'd15);
    k = 0;
    while (acc_data_q.size() < 10 && k < 200) begin
      tick();
      k++;
    end
    check_eq("t5_ten_words", 128'(acc_data_q.size() >= 10), 128'(1));
    rst = 1'b1;
    tick();
    check_idle_outputs("t5_rst");
    check_eq("t5_no_done", 128'(done_cyc_q.size()), 128'(0));
    tick();
    rst = 1'b0;
    clear_mon();
    fill(3);
    repeat (3) tick();
    exp_keep[0] = 4'b0111;
    do_start(4'd1, 4'd3);
    run("t5", 50, 1'b0);
    check_run("t5", 3, 1);

    // Test 6: second start while busy is ignored
    clear_mon();
    fill(5);
    for (int w = 0; w < 2; w++) exp_keep[w] = 4'hF;
    do_start(4'd2, 4'd4);
    m = 4'd15; n = 4'd15; start = 1'b1;
    tick();
    start = 1'b0;
    run("t6", 100, 1'b0);
    check_run("t6", 5, 2);
    check_eq("t6_idle_busy", 128'(busy), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
